pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised successor of the plain stall-able edge-triggered pipeline register.
- Adds a valid/ready handshake, a 2-entry skid buffer (so in_ready depends only on registered state plus stall), and a synchronous flush that inserts a bubble.
- On flush or drain, out_data is loaded with a configurable bubble value (RISC-V NOP by default).
- Used between the IF/ID/EX/MEM/WB stages of the five-stage core wherever back-pressure and branch/exception squash are needed.

Parameters:
- WIDTH, 32: bit width of the payload.
- BUBBLE_VALUE, 32'h0000_0013: value loaded into out_data on reset, flush or drain. Default is addi x0,x0,0. The value is truncated or zero-extended to WIDTH.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream presents a payload.
- in_ready  output  1  stage can accept a payload this cycle.
- in_data  input  WIDTH  upstream payload.
- stall  input  1  hazard-unit hold; freezes all state.
- flush  input  1  synchronous squash of all held payloads.
- out_valid  output  1  out_data holds a live payload.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  WIDTH  registered payload to the next stage.
- occupancy  output  2  number of held payloads (0, 1 or 2).

Behaviour:
- Reset: the clock and a single reset apply. Reset is asynchronous and active-low: while reset_n=0, out_valid=0, skid_valid=0, out_data=BUBBLE_VALUE, skid_data=0, occupancy=0. in_ready=1 whenever stall=0.
- Storage: main register (out_valid, out_data) plus skid register (skid_valid, skid_data). occupancy = out_valid + skid_valid, registered.
- in_ready = !skid_valid & !stall. This is combinational from stall only; there is no path from in_valid or out_ready to in_ready.
- in_fire = in_valid & in_ready.
- out_fire = out_valid & out_ready & !stall.
- Priority at each rising edge: flush > stall > normal operation.
- Flush (flush=1, regardless of stall):
  - Next state: out_valid=0, skid_valid=0, out_data=BUBBLE_VALUE.
  - Any in_fire in the same cycle is consumed and discarded; upstream sees a completed handshake.
- Stall (stall=1, flush=0):
  - All registers hold.
  - in_ready=0, so no in_fire occurs. out_fire=0 even if out_ready=1.
- EMPTY state (out_valid=0, skid_valid=0):
  - in_fire: load out_data<=in_data, out_valid<=1, go to FULL.
  - Otherwise hold.
- FULL state (out_valid=1, skid_valid=0):
  - in_fire & out_fire: out_data<=in_data, stay FULL.
  - in_fire & !out_fire: skid_data<=in_data, skid_valid<=1, go to SKID.
  - !in_fire & out_fire: out_valid<=0, out_data<=BUBBLE_VALUE, go to EMPTY.
  - Neither: hold.
- SKID state (out_valid=1, skid_valid=1):
  - in_ready=0.
  - out_fire: out_data<=skid_data, skid_valid<=0, go to FULL.
  - Otherwise hold.
- State out_valid=0 with skid_valid=1 is unreachable. The verification environment asserts it never occurs.
- Ordering: payloads leave strictly in acceptance order. Throughput is 1 payload/cycle when out_ready=1 and stall=0. Latency from in_fire to out_valid is 1 cycle.
- out_data and out_valid must not change while out_valid=1 & !out_fire, except on flush or reset.
- Reset asserted mid-operation discards both entries immediately (asynchronously). The first cycle after deassertion behaves as EMPTY.

Test Plan:
- Reset then pass-through: release reset_n, hold out_ready=1, drive in_data 0xA, 0xB, 0xC on consecutive cycles -> out_data 0xA, 0xB, 0xC one cycle later each; out_valid=1 for 3 cycles, then out_data=0x13; occupancy stays at most 1.
- Back-pressure and skid: out_ready=0, send 0x11 then 0x22 -> occupancy=2, in_ready=0, out_data=0x11. Raise out_ready -> 0x11 then 0x22 delivered in order; in_ready returns to 1 one cycle after the first out_fire.
- Stall hold: FULL with 0x55, assert stall=1 for 3 cycles with in_valid=1 and out_ready=1 -> in_ready=0, out_data=0x55 and occupancy=1 unchanged; after the stall drops, 0x55 is delivered.
- Flush beats stall: in SKID state (0x11, 0x22), assert flush=1 and stall=1 together -> next cycle out_valid=0, occupancy=0, out_data=0x13; no 0x11 or 0x22 ever appears with out_valid=1.
- Async reset mid-traffic: during a FULL->SKID transition, pulse reset_n=0 between clock edges -> out_valid=0 and occupancy=0 immediately without a clock edge; after release, new payload 0x77 passes with 1-cycle latency.
- Random soak: random in_valid, out_ready, stall and flush over 10k cycles -> scoreboard matches the in-order stream minus flushed payloads; a handshake-stability assertion holds.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Stall-able pipeline register with valid/ready handshake, a 2-entry skid buffer and
// a synchronous flush that replaces held payloads with a bubble instruction.
module pipe_stage_reg #(
  parameter int unsigned WIDTH        = 32,
  parameter logic [31:0] BUBBLE_VALUE = 32'h0000_0013
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  localparam logic [WIDTH-1:0] BUBBLE = WIDTH'(BUBBLE_VALUE);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b10,
    SKID  = 2'b11
  } state_e;

  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;

  logic             out_valid_nxt;
  logic             skid_valid_nxt;
  logic [WIDTH-1:0] out_data_nxt;
  logic [WIDTH-1:0] skid_data_nxt;

  state_e state;
  logic   in_fire;
  logic   out_fire;

  // in_ready looks only at registered state and stall, so no combinational
  // path runs from out_ready back to the upstream stage.
  assign in_ready = !skid_valid && !stall;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready && !stall;
  assign state    = state_e'({out_valid, skid_valid});

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    out_valid_nxt  = out_valid;
    skid_valid_nxt = skid_valid;
    out_data_nxt   = out_data;
    skid_data_nxt  = skid_data;
    if (flush) begin
      // A handshake accepted in the flush cycle is swallowed with the rest.
      out_valid_nxt  = 1'b0;
      skid_valid_nxt = 1'b0;
      out_data_nxt   = BUBBLE;
    end else if (!stall) begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            out_data_nxt  = in_data;
            out_valid_nxt = 1'b1;
          end
        end
        FULL: begin
          if (in_fire && out_fire) begin
            out_data_nxt = in_data;
          end else if (in_fire) begin
            skid_data_nxt  = in_data;
            skid_valid_nxt = 1'b1;
          end else if (out_fire) begin
            out_valid_nxt = 1'b0;
            out_data_nxt  = BUBBLE;
          end
        end
        SKID: begin
          if (out_fire) begin
            out_data_nxt   = skid_data;
            skid_valid_nxt = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering in simulation.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_data   <= BUBBLE;
      skid_data  <= '0;
      occupancy  <= 2'd0;
    end else begin
      out_valid  <= out_valid_nxt;
      skid_valid <= skid_valid_nxt;
      out_data   <= out_data_nxt;
      skid_data  <= skid_data_nxt;
      occupancy  <= {1'b0, out_valid_nxt} + {1'b0, skid_valid_nxt};
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and random bench for pipe_stage_reg; a queue model of the held payloads
// is compared against the outputs on every falling clock edge.
module tb_pipe_stage_reg;

  localparam int unsigned WIDTH  = 32;
  localparam logic [31:0] BUBBLE = 32'h0000_0013;

  logic             clock;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             stall;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;

  int vectors     = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] sb[$];
  logic             prev_hold = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;

  pipe_stage_reg #(.WIDTH(WIDTH), .BUBBLE_VALUE(BUBBLE)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .stall     (stall),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Reset empties the model immediately, matching the asynchronous clear.
  always @(negedge reset_n) begin
    sb.delete();
    prev_hold = 1'b0;
  end

  // Falling-edge monitor: compare against the model, then apply the handshakes
  // that the coming rising edge will perform.
  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      logic mdl_in_fire;
      logic mdl_out_fire;
      if (prev_hold) begin
        check("stable_valid", 32'(out_valid), 32'd1);
        check("stable_data", out_data, prev_data);
      end
      check("occupancy", 32'(occupancy), 32'(sb.size()));
      check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      check("in_ready", 32'(in_ready), 32'(sb.size() < 2 && !stall));
      if (sb.size() != 0) check("out_data", out_data, sb[0]);
      else                check("bubble", out_data, BUBBLE);

      mdl_in_fire  = in_valid && sb.size() < 2 && !stall;
      mdl_out_fire = sb.size() != 0 && out_ready && !stall;
      prev_hold    = sb.size() != 0 && !mdl_out_fire && !flush;
      prev_data    = out_data;
      if (flush) begin
        sb.delete();
      end else begin
        if (mdl_out_fire) void'(sb.pop_front());
        if (mdl_in_fire)  sb.push_back(in_data);
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    stall     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (2) cyc();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_out_data", out_data, BUBBLE);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    reset_n = 1'b1;
    cyc();

    // Pass-through at full rate.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hA; cyc();
    check("pt_a", out_data, 32'hA);
    check("pt_a_occ", 32'(occupancy), 32'd1);
    in_data   = 32'hB; cyc();
    check("pt_b", out_data, 32'hB);
    in_data   = 32'hC; cyc();
    check("pt_c", out_data, 32'hC);
    check("pt_c_valid", 32'(out_valid), 32'd1);
    in_valid  = 1'b0; cyc();
    check("pt_drain_valid", 32'(out_valid), 32'd0);
    check("pt_drain_data", out_data, BUBBLE);

    // Back-pressure fills the skid entry.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h11; cyc();
    in_data   = 32'h22; cyc();
    check("bp_occ", 32'(occupancy), 32'd2);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_head", out_data, 32'h11);
    in_valid  = 1'b0;
    out_ready = 1'b1; cyc();
    check("bp_second", out_data, 32'h22);
    check("bp_ready_back", 32'(in_ready), 32'd1);
    cyc();
    check("bp_empty", 32'(out_valid), 32'd0);

    // Stall freezes a FULL stage.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h55; cyc();
    stall     = 1'b1;
    out_ready = 1'b1;
    in_data   = 32'h66;
    #1;
    check("stall_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall_data", out_data, 32'h55);
      check("stall_occ", 32'(occupancy), 32'd1);
    end
    stall    = 1'b0;
    in_valid = 1'b0; cyc();
    check("stall_released", 32'(out_valid), 32'd0);

    // Flush overrides stall in SKID.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h11; cyc();
    in_data   = 32'h22; cyc();
    check("fl_skid_occ", 32'(occupancy), 32'd2);
    in_valid  = 1'b0;
    flush     = 1'b1;
    stall     = 1'b1; cyc();
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_occ", 32'(occupancy), 32'd0);
    check("fl_data", out_data, BUBBLE);
    flush     = 1'b0;
    stall     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("fl_no_ghost", 32'(out_valid), 32'd0);
    end

    // Asynchronous reset between edges during FULL->SKID.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h31; cyc();
    in_data   = 32'h32;
    #2 reset_n = 1'b0;
    #1;
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_occ", 32'(occupancy), 32'd0);
    check("ar_data", out_data, BUBBLE);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    cyc();
    check("ar_idle", 32'(out_valid), 32'd0);
    in_valid  = 1'b1;
    in_data   = 32'h77;
    out_ready = 1'b1; cyc();
    check("ar_77_valid", 32'(out_valid), 32'd1);
    check("ar_77_data", out_data, 32'h77);
    in_valid = 1'b0; cyc();
    check("ar_77_gone", 32'(out_valid), 32'd0);

    // Random soak; the falling-edge monitor does the checking.
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      stall     = ($urandom_range(0, 7) == 0);
      flush     = ($urandom_range(0, 31) == 0);
      cyc();
    end
    in_valid  = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (4) cyc();
    check("soak_drained", 32'(occupancy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
